ecall_unit: RTL
===============

# ecall_unit

Sequences an environment call (ecall) between the execute stage and the register file. It stalls the pipeline and waits for all older register writes to retire. It then snapshots argument registers a0–a7, presents them to the external service interface, and writes the returned value back into a0 through the register-file write port. The writeback stage muxes this block's write port ahead of its own.

## Interface
Parameters:
- XLEN, 64, data width of registers, arguments and return value
- A0_IDX, 5'd10, register index that receives the return value

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ecall_valid  in  1  execute stage presents an ecall (held until `ecall_done`)
- pipe_drained  in  1  no older instruction has a pending register write
- a0 … a7  in  XLEN each  live register-file argument outputs
- svc_req  out  1  service request valid
- svc_num  out  XLEN  syscall number (snapshot of a7)
- svc_arg0 … svc_arg6  out  XLEN each  snapshot of a0 … a6
- svc_ack  in  1  service complete; `svc_ret` valid this cycle
- svc_ret  in  XLEN  service return value
- stall  out  1  freeze fetch/decode/execute
- wb_en  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- ecall_done  out  1  one-cycle pulse; ecall retired
- ecall_count  out  32  number of completed ecalls

## Operation
States: IDLE, DRAIN, REQ, WB, DONE.
- **IDLE**
  - `stall`=`ecall_valid`, so the stall is combinational in the accept cycle.
  - On `ecall_valid` → DRAIN.
- **DRAIN**
  - `stall`=1.
  - When `pipe_drained`=1: capture a0–a7 into argument registers, then → REQ.
  - Otherwise remain in DRAIN indefinitely.
- **REQ**
  - `stall`=1, `svc_req`=1.
  - Argument outputs come from the snapshot only and are stable for the whole request.
  - `svc_ack` is sampled only in REQ. An ack seen in any other state is ignored.
  - On `svc_ack`: capture `svc_ret` → WB.
- **WB**
  - `stall`=1, `wb_en`=1, `wb_addr`=`A0_IDX`, `wb_data`=captured return value.
  - Exactly one cycle → DONE.
- **DONE**
  - `stall`=1, `ecall_done`=1, `ecall_count` increments.
  - → IDLE. The execute stage drops `ecall_valid` in the following cycle.
  - A `ecall_valid` still high in the first IDLE cycle is a new ecall only if the execute stage re-asserts it after a low cycle. The bench holds it low for at least one cycle after `ecall_done`.
- **Default outputs:** whenever not stated above, `wb_en`=0, `wb_addr`=0 and `wb_data`=0, so the unit never drives a write outside WB.
- **Counter:** `ecall_count` wraps modulo 2^32.

## Timing
- **Reset values:** state=IDLE; `svc_req`=0, `wb_en`=0, `ecall_done`=0; all `svc_*` data outputs 0; `wb_addr`/`wb_data`=0; `ecall_count`=0. `stall` follows `ecall_valid` combinationally.
- **Reset mid-operation:** from any state, return to IDLE on the next edge. No write-back, no `ecall_done`, no count increment. `svc_req` drops the same cycle reset is sampled.
- **Minimum latency, drained pipeline:** `ecall_valid` at cycle 0, DRAIN at 1 (snapshot taken), REQ at 2.
  - An ack at cycle 2 gives WB at 3 and DONE at 4.
  - Total: 5 cycles of stall, counting cycle 0.
- **Snapshot timing:** arguments are taken on the DRAIN cycle in which `pipe_drained` is first high. Later changes to a0–a7 are not visible on `svc_*`.
- **Simultaneous `svc_ack` on the first REQ cycle:** legal, one-cycle request.
- **`pipe_drained` low in DRAIN:** no state change, `svc_req` stays 0.

## Structure
- **Shared package:**
  - ABI register-index constants A0–A7 (A0=10 … A7=17), used by both the register file and this block.
  - The `ecall_state_t` enum (IDLE, DRAIN, REQ, WB, DONE).
- Single module, no sub-module. The FSM, snapshot registers, return register and counter together are about 150–200 lines.

## Test plan
- **Basic ecall:** a0..a7 = 1..8, `pipe_drained`=1, ack on the first REQ cycle with `svc_ret`=0x55.
  - `svc_num`=8, `svc_arg0..6`=1..7.
  - Single `wb_en` cycle writing reg 10 with 0x55.
  - `ecall_done` at cycle 4; `ecall_count`=1.
- **Drain wait:** `pipe_drained` low for 3 cycles and a0 changes during them.
  - `svc_req` stays 0.
  - The snapshot holds the a0 value present in the first cycle `pipe_drained`=1.
- **Slow service:** ack arrives 10 cycles into REQ; a0–a7 are changed during REQ.
  - `svc_*` outputs stay constant.
  - `stall` is high for the whole duration.
  - Exactly one write-back.
- **Spurious ack:** `svc_ack` pulsed in IDLE and in DRAIN.
  - No state change and no write.
- **Reset in REQ:** assert `reset` for one cycle mid-request.
  - `svc_req`=0, `wb_en` never asserted, `ecall_count` unchanged at 0.
  - A following ecall completes normally.
- **Back-to-back:** two ecalls separated by one idle cycle, returns 0xA and 0xB.
  - Two write-backs to reg 10 in order.
  - `ecall_count`=2.

Source files
------------

// File: rtl/ecall_unit_pkg.sv
// Shared definitions for the ecall sequencer: ABI argument-register indices
// and the sequencer state encoding.
package ecall_unit_pkg;

    localparam logic [4:0] ABI_A0 = 5'd10;
    localparam logic [4:0] ABI_A1 = 5'd11;
    localparam logic [4:0] ABI_A2 = 5'd12;
    localparam logic [4:0] ABI_A3 = 5'd13;
    localparam logic [4:0] ABI_A4 = 5'd14;
    localparam logic [4:0] ABI_A5 = 5'd15;
    localparam logic [4:0] ABI_A6 = 5'd16;
    localparam logic [4:0] ABI_A7 = 5'd17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        REQ   = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } ecall_state_t;

endpackage

// File: rtl/ecall_unit.sv
// Environment-call sequencer: stalls the pipeline, waits for older writes to
// retire, snapshots a0-a7 for the service interface and writes the result to a0.
module ecall_unit
    import ecall_unit_pkg::*;
#(
    parameter int         XLEN   = 64,
    parameter logic [4:0] A0_IDX = ABI_A0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ecall_valid,
    input  logic            pipe_drained,
    input  logic [XLEN-1:0] a0,
    input  logic [XLEN-1:0] a1,
    input  logic [XLEN-1:0] a2,
    input  logic [XLEN-1:0] a3,
    input  logic [XLEN-1:0] a4,
    input  logic [XLEN-1:0] a5,
    input  logic [XLEN-1:0] a6,
    input  logic [XLEN-1:0] a7,
    output logic            svc_req,
    output logic [XLEN-1:0] svc_num,
    output logic [XLEN-1:0] svc_arg0,
    output logic [XLEN-1:0] svc_arg1,
    output logic [XLEN-1:0] svc_arg2,
    output logic [XLEN-1:0] svc_arg3,
    output logic [XLEN-1:0] svc_arg4,
    output logic [XLEN-1:0] svc_arg5,
    output logic [XLEN-1:0] svc_arg6,
    input  logic            svc_ack,
    input  logic [XLEN-1:0] svc_ret,
    output logic            stall,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            ecall_done,
    output logic [31:0]     ecall_count
);

    ecall_state_t    r_state;
    ecall_state_t    w_next;
    logic [XLEN-1:0] r_arg [0:7];
    logic [XLEN-1:0] r_ret;
    logic [31:0]     r_count;
    logic            w_snap;
    logic            w_take_ret;

    assign w_snap     = (r_state == DRAIN) && pipe_drained;
    assign w_take_ret = (r_state == REQ) && svc_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an ack outside REQ never moves the sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (ecall_valid) begin
                    w_next = DRAIN;
                end else begin
                    w_next = IDLE;
                end
            end
            DRAIN: begin
                if (pipe_drained) begin
                    w_next = REQ;
                end else begin
                    w_next = DRAIN;
                end
            end
            REQ: begin
                if (svc_ack) begin
                    w_next = WB;
                end else begin
                    w_next = REQ;
                end
            end
            WB:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode; the write port stays zero outside WB.
    always_comb begin
        stall      = 1'b0;
        svc_req    = 1'b0;
        wb_en      = 1'b0;
        wb_addr    = 5'd0;
        wb_data    = {XLEN{1'b0}};
        ecall_done = 1'b0;
        case (r_state)
            IDLE:  stall = ecall_valid;
            DRAIN: stall = 1'b1;
            REQ: begin
                stall   = 1'b1;
                svc_req = 1'b1;
            end
            WB: begin
                stall   = 1'b1;
                wb_en   = 1'b1;
                wb_addr = A0_IDX;
                wb_data = r_ret;
            end
            DONE: begin
                stall      = 1'b1;
                ecall_done = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    // Argument snapshot, taken on the first drained DRAIN cycle only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_arg[i] <= {XLEN{1'b0}};
            end
        end else if (w_snap) begin
            r_arg[0] <= a0;
            r_arg[1] <= a1;
            r_arg[2] <= a2;
            r_arg[3] <= a3;
            r_arg[4] <= a4;
            r_arg[5] <= a5;
            r_arg[6] <= a6;
            r_arg[7] <= a7;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_arg[i] <= r_arg[i];
            end
        end
    end

    // Return-value capture on the accepted ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ret <= {XLEN{1'b0}};
        end else if (w_take_ret) begin
            r_ret <= svc_ret;
        end else begin
            r_ret <= r_ret;
        end
    end

    // Completion counter; it advances entering DONE so it reads new with ecall_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (r_state == WB) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign svc_arg0    = r_arg[0];
    assign svc_arg1    = r_arg[1];
    assign svc_arg2    = r_arg[2];
    assign svc_arg3    = r_arg[3];
    assign svc_arg4    = r_arg[4];
    assign svc_arg5    = r_arg[5];
    assign svc_arg6    = r_arg[6];
    assign svc_num     = r_arg[7];
    assign ecall_count = r_count;

endmodule
